// File: rtl/alu_share_arbiter.sv
`default_nettype none
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters, with registered ALU operands and registered response.
module alu_share_arbiter #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [2:0]        flags_q, flags_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic grant0;
  logic grant1;
  logic rsp_fire;

  // On a tie the requester not served last wins; ready is forced low in reset.
  assign grant0 = rst_n && (state_q == S_IDLE) && req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = rst_n && (state_q == S_IDLE) && req1_valid && (!req0_valid || !last_grant_q);

  assign rsp_fire = (state_q == S_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;
    flags_d      = flags_q;
    count_d      = count_q;
    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          alu_a_d  = req0_a;
          alu_b_d  = req0_b;
          alu_op_d = req0_op;
          owner_d  = 1'b0;
          state_d  = S_EXEC;
        end else if (grant1) begin
          alu_a_d  = req1_a;
          alu_b_d  = req1_b;
          alu_op_d = req1_op;
          owner_d  = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        flags_d  = {alu_carry, alu_overflow, alu_zero};
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_fire) begin
          last_grant_d = owner_q;
          count_d      = count_q + CNT_W'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      count_q      <= count_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid = (state_q == S_RESP) && owner_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign busy       = (state_q != S_IDLE);
  assign op_count   = count_q;

endmodule
`default_nettype wire
